// File: rtl/fp_md_result_buffer.sv
// Result capture stage for the FP mul/div core: tracks issued ops through a
// delay line, buffers completed results in a FIFO, and provides issue credit.
module fp_md_result_buffer #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 4
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        en,
  input  logic        sel,
  input  logic [31:0] R,
  input  logic        IO,
  input  logic        DZ,
  input  logic        OF,
  input  logic        UF,
  input  logic        I,
  output logic        can_issue,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [4:0]  res_flags,
  output logic        res_sel,
  output logic [4:0]  sticky_flags,
  input  logic        flags_clr,
  output logic        drop_err
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned IF_W  = $clog2(LATENCY + 1);
  localparam int unsigned OCC_W = 32;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  flags;
    logic        sel;
  } entry_t;

  logic [LATENCY-1:0] dl_en_q, dl_en_d;
  logic [LATENCY-1:0] dl_sel_q, dl_sel_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [4:0]         sticky_q, sticky_d;
  logic               drop_err_q, drop_err_d;
  entry_t             mem_q [DEPTH];

  logic [4:0]       cur_flags;
  logic             complete;
  logic             pop;
  logic             push;
  logic             drop;
  logic             full_after_pop;
  logic [IF_W-1:0]  in_flight;
  logic [OCC_W-1:0] occupancy;
  entry_t           wr_entry;
  entry_t           head;

  assign cur_flags = {IO, DZ, OF, UF, I};
  assign complete  = dl_en_q[LATENCY-1];

  // Issue delay line: the last stage marks the cycle the core result is valid.
  always_comb begin
    dl_en_d     = dl_en_q;
    dl_sel_d    = dl_sel_q;
    dl_en_d[0]  = en;
    dl_sel_d[0] = sel;
    for (int i = 1; i < int'(LATENCY); i++) begin
      dl_en_d[i]  = dl_en_q[i-1];
      dl_sel_d[i] = dl_sel_q[i-1];
    end
  end

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < int'(LATENCY); i++) begin
      in_flight = in_flight + IF_W'(dl_en_q[i]);
    end
  end

  // Credit ignores same-cycle pops, so every tracked op is guaranteed a slot.
  assign occupancy = OCC_W'(count_q) + OCC_W'(in_flight);
  assign can_issue = occupancy < OCC_W'(DEPTH);

  assign res_valid      = (count_q != '0);
  assign pop            = res_valid && res_ready;
  assign full_after_pop = (count_q == CNT_W'(DEPTH)) && !pop;
  assign push           = complete && !full_after_pop;
  assign drop           = complete && full_after_pop;

  always_comb begin
    wr_entry.data  = R;
    wr_entry.flags = cur_flags;
    wr_entry.sel   = dl_sel_q[LATENCY-1];
  end

  // FIFO pointer/count update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Clear first so a same-cycle completion's flags survive the clear.
  always_comb begin
    sticky_d   = sticky_q;
    drop_err_d = drop_err_q | drop;
    if (flags_clr) begin
      sticky_d = '0;
    end
    if (complete) begin
      sticky_d = sticky_d | cur_flags;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      dl_en_q    <= '0;
      dl_sel_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sticky_q   <= '0;
      drop_err_q <= 1'b0;
    end else begin
      dl_en_q    <= dl_en_d;
      dl_sel_q   <= dl_sel_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sticky_q   <= sticky_d;
      drop_err_q <= drop_err_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign res_data     = res_valid ? head.data  : '0;
  assign res_flags    = res_valid ? head.flags : '0;
  assign res_sel      = res_valid ? head.sel   : 1'b0;
  assign sticky_flags = sticky_q;
  assign drop_err     = drop_err_q;

endmodule
